// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, ASCII constants and element-buffer sizes for the Morse decoder
package morse_pkg;
  typedef enum logic [2:0] {IDLE, MARK, SPACE, WAIT_WORD, STUCK} state_t;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam int ELEM_W = 6;
  localparam int LEN_W = 3;
  localparam logic [LEN_W-1:0] MAX_LEN = 3'd6;
endpackage

// File: rtl/morse_if.sv
// morse_if: decoded byte stream (charData/charValid/charReady) plus overrun and error pulses
interface morse_if;
  logic [7:0] charData;
  logic charValid;
  logic charReady;
  logic overrun;
  logic error;
  modport master(output charData, charValid, overrun, error, input charReady);
  modport slave(input charData, charValid, overrun, error, output charReady);
endinterface

// File: rtl/morse_lut.sv
// morse_lut: maps {len, pattern} (dash=1, first element in MSB of used field) to ASCII, '?' otherwise
// ports: len[2:0] element count, pattern[5:0] elements, ascii[7:0] decoded byte
module morse_lut import morse_pkg::*; (
  input  logic [LEN_W-1:0]  len,
  input  logic [ELEM_W-1:0] pattern,
  output logic [7:0]        ascii
);
  always_comb
    case ({len, pattern})
      {3'd2, 6'b000001}: ascii = "A";
      {3'd4, 6'b001000}: ascii = "B";
      {3'd4, 6'b001010}: ascii = "C";
      {3'd3, 6'b000100}: ascii = "D";
      {3'd1, 6'b000000}: ascii = "E";
      {3'd4, 6'b000010}: ascii = "F";
      {3'd3, 6'b000110}: ascii = "G";
      {3'd4, 6'b000000}: ascii = "H";
      {3'd2, 6'b000000}: ascii = "I";
      {3'd4, 6'b000111}: ascii = "J";
      {3'd3, 6'b000101}: ascii = "K";
      {3'd4, 6'b000100}: ascii = "L";
      {3'd2, 6'b000011}: ascii = "M";
      {3'd2, 6'b000010}: ascii = "N";
      {3'd3, 6'b000111}: ascii = "O";
      {3'd4, 6'b000110}: ascii = "P";
      {3'd4, 6'b001101}: ascii = "Q";
      {3'd3, 6'b000010}: ascii = "R";
      {3'd3, 6'b000000}: ascii = "S";
      {3'd1, 6'b000001}: ascii = "T";
      {3'd3, 6'b000001}: ascii = "U";
      {3'd4, 6'b000001}: ascii = "V";
      {3'd3, 6'b000011}: ascii = "W";
      {3'd4, 6'b001001}: ascii = "X";
      {3'd4, 6'b001011}: ascii = "Y";
      {3'd4, 6'b001100}: ascii = "Z";
      {3'd5, 6'b011111}: ascii = "0";
      {3'd5, 6'b001111}: ascii = "1";
      {3'd5, 6'b000111}: ascii = "2";
      {3'd5, 6'b000011}: ascii = "3";
      {3'd5, 6'b000001}: ascii = "4";
      {3'd5, 6'b000000}: ascii = "5";
      {3'd5, 6'b010000}: ascii = "6";
      {3'd5, 6'b011000}: ascii = "7";
      {3'd5, 6'b011100}: ascii = "8";
      {3'd5, 6'b011110}: ascii = "9";
      default:           ascii = ASCII_QMARK;
    endcase
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: times a debounced key in dot units, classifies marks/spaces and streams decoded ASCII
// ports: clk, resetN (async, active-low), key (1 = mark), stream (master: charData/charValid/charReady/overrun/error)
module morse_decoder import morse_pkg::*; #(
  parameter real frequency    = 60_000_000.0,
  parameter real unitTime     = 0.06,
  parameter int  dashUnits    = 2,
  parameter int  charGapUnits = 2,
  parameter int  wordGapUnits = 5,
  parameter int  maxMarkUnits = 15
)(
  input  logic     clk,
  input  logic     resetN,
  input  logic     key,
  morse_if.master  stream
);
  localparam int UNIT_CYCLES = int'(frequency * unitTime);
  localparam int PW = $clog2(UNIT_CYCLES + 1);
  logic [PW-1:0] pre;
  logic [3:0] units;
  logic key_q;
  state_t state;
  logic [ELEM_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic ovf;
  logic [7:0] ascii, emit_byte;
  logic edge_det, tick, adv, char_done, word_done, stuck, emit, take;
  morse_lut lut (.len(len), .pattern(pat), .ascii(ascii));
  // a key edge restarts timing and overrides a coincident tick
  assign edge_det = key ^ key_q;
  assign tick = pre == PW'(UNIT_CYCLES - 1);
  assign adv = tick & ~edge_det;
  assign char_done = adv && units == 4'(charGapUnits - 1);
  assign word_done = adv && units == 4'(wordGapUnits - 1);
  assign stuck = adv && units == 4'(maxMarkUnits - 1);
  assign emit = (state == SPACE && !key && char_done) || (state == WAIT_WORD && !key && word_done);
  assign emit_byte = state == WAIT_WORD ? ASCII_SPACE : ovf ? ASCII_QMARK : ascii;
  assign take = emit && (!stream.charValid || stream.charReady);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      key_q <= 1'b0;
      pre <= '0;
      units <= '0;
    end else begin
      key_q <= key;
      pre <= (edge_det || tick) ? '0 : pre + 1'b1;
      units <= edge_det ? 4'd0 : (tick && units != 4'd15) ? units + 4'd1 : units;
    end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      pat <= '0;
      len <= '0;
      ovf <= 1'b0;
      stream.charData <= 8'h00;
      stream.charValid <= 1'b0;
      stream.overrun <= 1'b0;
      stream.error <= 1'b0;
    end else begin
      stream.error <= (state == MARK && key && stuck) || (state == SPACE && !key && char_done && ovf);
      stream.overrun <= emit && !take;
      if (take) begin
        stream.charData <= emit_byte;
        stream.charValid <= 1'b1;
      end else if (stream.charValid && stream.charReady)
        stream.charValid <= 1'b0;
      case (state)
        IDLE: if (key) state <= MARK;
        MARK:
          if (!key) begin
            if (len == MAX_LEN)
              ovf <= 1'b1;
            else begin
              pat <= {pat[ELEM_W-2:0], units >= 4'(dashUnits)};
              len <= len + 3'd1;
            end
            state <= SPACE;
          end else if (stuck) begin
            pat <= '0;
            len <= '0;
            ovf <= 1'b0;
            state <= STUCK;
          end
        SPACE:
          if (key)
            state <= MARK;
          else if (char_done) begin
            pat <= '0;
            len <= '0;
            ovf <= 1'b0;
            state <= WAIT_WORD;
          end
        WAIT_WORD: state <= key ? MARK : word_done ? IDLE : WAIT_WORD;
        STUCK: if (!key) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: table-driven character vectors plus directed multi-cycle sequences for morse_decoder
module tb_morse_decoder;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic key = 1'b0;
  morse_if bus();
  morse_decoder #(.frequency(100.0), .unitTime(0.1)) dut (
    .clk(clk), .resetN(resetN), .key(key), .stream(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] len;
    logic [5:0] pat;
    logic [7:0] ch;
  } vec_t;
  vec_t tbl [11];
  int n_vec = 0;
  int n_bad = 0;
  int n_ovr = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned err_cyc = 0;
  logic [7:0] rx[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (resetN) begin
      if (bus.charValid && bus.charReady) rx.push_back(bus.charData);
      if (bus.overrun) n_ovr++;
      if (bus.error) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] at(input int i);
    return i < rx.size() ? 32'(rx[i]) : 32'hFFFF_FFFF;
  endfunction
  task automatic do_reset();
    resetN = 1'b0;
    step(3);
    resetN = 1'b1;
    rx.delete();
    n_ovr = 0;
    n_err = 0;
  endtask
  task automatic mark(input int n);
    key = 1'b1;
    step(n);
    key = 1'b0;
  endtask
  task automatic send(input int len, input logic [5:0] pat);
    for (int i = len - 1; i >= 0; i--) begin
      mark(pat[i] ? 30 : 10);
      if (i > 0) step(10);
    end
  endtask
  initial begin
    int lat;
    int unsigned c_rise;
    tbl = '{
      '{3'd2, 6'b000001, 8'h41}, '{3'd4, 6'b001000, 8'h42}, '{3'd1, 6'b000000, 8'h45},
      '{3'd1, 6'b000001, 8'h54}, '{3'd4, 6'b001101, 8'h51}, '{3'd4, 6'b001100, 8'h5A},
      '{3'd5, 6'b011111, 8'h30}, '{3'd5, 6'b000000, 8'h35}, '{3'd5, 6'b011110, 8'h39},
      '{3'd4, 6'b001111, 8'h3F}, '{3'd6, 6'b000000, 8'h3F}
    };
    bus.charReady = 1'b0;
    step(2);
    chk("reset charData", bus.charData, 0);
    chk("reset charValid", bus.charValid, 0);
    chk("reset overrun", bus.overrun, 0);
    chk("reset error", bus.error, 0);
    resetN = 1'b1;
    bus.charReady = 1'b1;
    for (int v = 0; v < 11; v++) begin
      rx.delete();
      send(int'(tbl[v].len), tbl[v].pat);
      step(30);
      chk($sformatf("table %0d count", v), rx.size(), 1);
      chk($sformatf("table %0d byte", v), at(0), 32'(tbl[v].ch));
    end
    // 'A' latency with output held while not accepted
    do_reset();
    bus.charReady = 1'b0;
    mark(10); step(10); mark(30);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (bus.charValid && lat == 0) lat = i;
    end
    chk("A latency", lat, 21);
    chk("A data", bus.charData, 8'h41);
    chk("A held", bus.charValid, 1);
    bus.charReady = 1'b1;
    step(1);
    chk("A accepted", at(0), 8'h41);
    // 'E' followed by a word gap gives exactly one space
    do_reset();
    mark(10);
    step(80);
    chk("E+gap count", rx.size(), 2);
    chk("E+gap char", at(0), 8'h45);
    chk("E+gap space", at(1), 8'h20);
    step(100);
    chk("single space", rx.size(), 2);
    // seven elements overflow the buffer
    do_reset();
    send(6, 6'b000000);
    step(10);
    mark(10);
    step(30);
    chk("overflow error", n_err, 1);
    chk("overflow count", rx.size(), 1);
    chk("overflow byte", at(0), 8'h3F);
    // overrun: 'T' completes while 'E' is pending
    do_reset();
    bus.charReady = 1'b0;
    mark(10); step(30); mark(30); step(30);
    chk("overrun pulses", n_ovr, 1);
    chk("overrun held data", bus.charData, 8'h45);
    chk("overrun held valid", bus.charValid, 1);
    bus.charReady = 1'b1;
    step(1);
    bus.charReady = 1'b0;
    chk("overrun accepted", at(0), 8'h45);
    chk("overrun count", rx.size(), 1);
    chk("overrun no T", bus.charValid, 0);
    // reset mid-character with a byte pending
    do_reset();
    bus.charReady = 1'b0;
    mark(10); step(30); mark(10); step(10); mark(10);
    resetN = 1'b0;
    step(3);
    chk("midreset charData", bus.charData, 0);
    chk("midreset charValid", bus.charValid, 0);
    chk("midreset overrun", bus.overrun, 0);
    chk("midreset error", bus.error, 0);
    resetN = 1'b1;
    rx.delete();
    bus.charReady = 1'b1;
    mark(30);
    step(30);
    chk("post-reset count", rx.size(), 1);
    chk("post-reset T", at(0), 8'h54);
    // stuck key
    do_reset();
    c_rise = cyc;
    mark(200);
    step(30);
    chk("stuck error", n_err, 1);
    chk("stuck timing", err_cyc - c_rise, 151);
    chk("stuck no char", rx.size(), 0);
    mark(10);
    step(30);
    chk("after stuck E", at(0), 8'h45);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
